// File: rtl/minterm_encoder_seq_pkg.sv
// minterm_encoder_seq_pkg: shared widths and FSM state encoding for the minterm encoder.
package minterm_encoder_seq_pkg;
    localparam int MINT_W = 16;
    localparam int MINT_IDX_W = $clog2(MINT_W);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/minterm_encoder_seq_if.sv
// minterm_encoder_seq_if: load request, minterm vector and index stream handshake.
interface minterm_encoder_seq_if;
    import minterm_encoder_seq_pkg::*;
    logic en;
    logic start;
    logic [0:MINT_W-1] m_in;
    logic [MINT_IDX_W-1:0] idx_out;
    logic valid;
    logic ready;
    logic last;
    logic busy;
    logic done;
    logic [MINT_IDX_W:0] count;
    modport master (
        output en, start, m_in, ready,
        input idx_out, valid, last, busy, done, count
    );
    modport slave (
        input en, start, m_in, ready,
        output idx_out, valid, last, busy, done, count
    );
endinterface

// File: rtl/minterm_encoder_seq_prio_enc_lsb.sv
// prio_enc_lsb: index of the lowest set bit of v, plus a nonzero flag.
module prio_enc_lsb #(
    parameter int W = 16,
    parameter int IDX_W = 4
) (
    input  logic [W-1:0] v,
    output logic [IDX_W-1:0] idx,
    output logic nz
);
    always_comb begin
        idx = '0;
        for (int k = W - 1; k >= 0; k--)
            if (v[k]) idx = IDX_W'(k);
    end
    assign nz = |v;
endmodule

// File: rtl/minterm_encoder_seq.sv
// minterm_encoder_seq: serially emits the index of every set minterm, lowest first,
// over a valid/ready handshake.
module minterm_encoder_seq
    import minterm_encoder_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    minterm_encoder_seq_if.slave bus
);
    localparam int W = MINT_W;
    localparam int IDX_W = MINT_IDX_W;
    localparam logic [IDX_W:0] CNT_ONE = (IDX_W + 1)'(1);
    state_t state;
    logic [W-1:0] pending, m_le, rest;
    logic [IDX_W-1:0] low_idx;
    logic [IDX_W:0] cnt;
    logic nz, single;
    // m_in is declared [0:W-1]; bit k must land on weight 2^k so pending-1 clears the lowest minterm
    always_comb begin
        m_le = '0;
        for (int k = 0; k < W; k++)
            m_le[k] = bus.m_in[k];
    end
    prio_enc_lsb #(.W(W), .IDX_W(IDX_W)) u_prio (
        .v(pending),
        .idx(low_idx),
        .nz(nz)
    );
    assign rest = pending & (pending - W'(1));
    assign single = nz && (rest == '0);
    assign bus.idx_out = low_idx;
    assign bus.valid = (state == SCAN);
    assign bus.busy = (state == SCAN);
    assign bus.last = (state == SCAN) && single;
    assign bus.done = (state == DONE);
    assign bus.count = cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pending <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start && bus.en) begin
                    pending <= m_le;
                    cnt <= '0;
                    state <= (m_le != '0) ? SCAN : DONE;
                end
                SCAN: if (bus.ready) begin
                    pending <= rest;
                    cnt <= cnt + CNT_ONE;
                    if (single) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
